// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression core: one round per clock over a 16-word schedule window.
// Presents the raw final working variables a..h; the IV addition is done downstream.
module sha256_round_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] msg_in,
  input  logic [255:0] iv_in,
  output logic         busy,
  output logic         done,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic [31:0]  e_out,
  output logic [31:0]  f_out,
  output logic [31:0]  g_out,
  output logic [31:0]  h_out,
  output logic [1:0]   state_o
);

  // Handshake: start is a level request sampled on posedge only in IDLE or DONE;
  // done is a single-cycle strobe, and a_out..h_out stay stable until the next done.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] out_q [8];
  logic [31:0] out_d [8];
  logic [31:0] t1, t2, w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] t);
    logic [31:0] k;
    case (t)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; default: k = 32'hc67178f2;
    endcase
    return k;
  endfunction

  // Round datapath; v_q[0..7] are a..h, w_q[0] is W[t].
  always_comb begin
    t1 = v_q[7]
       + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + k_rom(t_q) + w_q[0];
    t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
          + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
          + w_q[0];
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    v_d     = v_q;
    w_d     = w_q;
    out_d   = out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          t_d     = 6'd0;
          for (int i = 0; i < 8; i++)  v_d[i] = iv_in[255 - 32*i -: 32];
          for (int i = 0; i < 16; i++) w_d[i] = msg_in[511 - 32*i -: 32];
        end
      end
      RUN: begin
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        t_d     = t_q + 6'd1;
        // Capture on the last round so the result is already stable in the DONE cycle.
        if (t_q == 6'(ROUNDS - 1)) begin
          state_d = DONE;
          out_d   = v_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        v_q[i]   <= 32'd0;
        out_q[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      v_q     <= v_d;
      w_q     <= w_d;
      out_q   <= out_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign state_o = state_q;
  assign a_out   = out_q[0];
  assign b_out   = out_q[1];
  assign c_out   = out_q[2];
  assign d_out   = out_q[3];
  assign e_out   = out_q[4];
  assign f_out   = out_q[5];
  assign g_out   = out_q[6];
  assign h_out   = out_q[7];

endmodule

// File: tb/tb_sha256_round_core.sv
// Directed bench for sha256_round_core: "abc" and empty-string blocks with known raw results,
// latency, ignored mid-run start, mid-run reset and back-to-back start through DONE.
module tb_sha256_round_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [511:0] msg_in;
  logic [255:0] iv_in;
  logic         busy, done;
  logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
  logic [1:0]   state_o;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  // Final digest minus IV, word by word (a..h).
  localparam logic [255:0] RES_ABC   = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                                        32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
  localparam logic [255:0] RES_EMPTY = {32'h79a6dddb, 32'hdd946d8f, 32'h5e8d0156, 32'hf41fc3ea,
                                        32'hd69fef65, 32'hc9962ac0, 32'h8511bf70, 32'h1c71eb3c};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sha256_round_core #(.ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_in(msg_in), .iv_in(iv_in),
    .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .e_out(e_out), .f_out(f_out), .g_out(g_out), .h_out(h_out),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_result(input string tag, input logic [255:0] exp_v);
    logic [255:0] obs;
    obs = {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_w%0d", tag, i), obs[255 - 32*i -: 32], exp_v[255 - 32*i -: 32]);
  endtask

  // Returns the cycle stamp at which done was seen, or -1 when the budget expires.
  task automatic wait_done(input int budget, output int seen_at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    seen_at = (done === 1'b1) ? cyc : -1;
  endtask

  task automatic count_dones(input int cycles, output int n_done);
    n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
  endtask

  initial begin
    int acc, at, at2, n_done;

    // Reset held for two cycles
    rst = 1'b1; start = 1'b0; msg_in = '0; iv_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk_result("rst_out", 256'h0);

    // "abc" block with latency measurement
    msg_in = MSG_ABC; iv_in = IV; start = 1'b1;
    tick(); acc = cyc; start = 1'b0;
    chk("lat_busy_after_accept", 32'(busy), 32'd1);
    chk("lat_no_early_done", 32'(done), 32'd0);
    wait_done(100, at);
    chk("lat_abc", 32'(at - acc), 32'd64);
    chk("abc_busy_in_done", 32'(busy), 32'd0);
    chk_result("abc", RES_ABC);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(state_o), 32'd0);
    chk("abc_hold_a", a_out, 32'h506e3058);

    // start pulsed at round 10 with a different message is ignored
    msg_in = MSG_ABC; start = 1'b1;
    tick(); acc = cyc; start = 1'b0;
    repeat (10) tick();
    msg_in = MSG_EMPTY; iv_in = ~IV; start = 1'b1;
    tick(); start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    wait_done(100, at);
    chk("ign_lat", 32'(at - acc), 32'd64);
    chk_result("ign", RES_ABC);
    count_dones(80, n_done);
    chk("ign_single_done", 32'(n_done), 32'd0);

    // Reset at round 30 aborts the block; outputs clear
    msg_in = MSG_ABC; iv_in = IV; start = 1'b1;
    tick(); start = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out_a", a_out, 32'd0);
    count_dones(80, n_done);
    chk("abort_no_done", 32'(n_done), 32'd0);
    msg_in = MSG_EMPTY; start = 1'b1;
    tick(); acc = cyc; start = 1'b0;
    wait_done(100, at);
    chk("empty_lat", 32'(at - acc), 32'd64);
    chk_result("empty", RES_EMPTY);

    // start held through DONE: the next block is accepted on the DONE cycle's edge
    msg_in = MSG_ABC; start = 1'b1;
    tick(); acc = cyc;
    wait_done(100, at);
    chk("b2b_lat1", 32'(at - acc), 32'd64);
    chk_result("b2b_first", RES_ABC);
    msg_in = MSG_EMPTY;
    tick(); acc = cyc; start = 1'b0;
    chk("b2b_busy_no_idle", 32'(busy), 32'd1);
    chk("b2b_done_dropped", 32'(done), 32'd0);
    chk("b2b_hold_a", a_out, 32'h506e3058);
    wait_done(100, at2);
    chk("b2b_lat2", 32'(at2 - acc), 32'd64);
    chk("b2b_spacing", 32'(at2 - at), 32'd65);
    chk_result("b2b_second", RES_EMPTY);
    tick();
    chk("b2b_idle_end", 32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
